// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander: loads W0..W15 one word per handshake,
// then streams W0..W63 to the round engine through a sliding 16-word window.
module sha256_msg_schedule #(
  parameter int WORD_W = 32,  // rotation amounts below assume 32
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [5:0]        out_idx,
  output logic              out_last,
  output logic              busy
);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  state_e            state_q;
  logic [5:0]        cnt_q;
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] win15_d;
  logic              last_cnt;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign last_cnt = (cnt_q == 6'(ROUNDS - 1));

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    win15_d = '0;
    // Words past W[ROUNDS-1] are never emitted, so the tail of the window is zero-filled.
    if (cnt_q < 6'(ROUNDS - 16)) begin
      win15_d = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      // NOTE: the window is reset explicitly, since it is also the out_word
      // source and a mid-block reset must leave no stale words behind.
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_valid) begin
            win_q[cnt_q[3:0]] <= in_word;
            if (cnt_q == 6'd15) begin
              cnt_q   <= '0;
              state_q <= ST_EMIT;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            for (int i = 0; i < 15; i++) begin
              win_q[i] <= win_q[i+1];
            end
            win_q[15] <= win15_d;
            if (last_cnt) begin
              cnt_q   <= '0;
              state_q <= ST_LOAD;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        default: begin
          state_q <= ST_LOAD;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // All outputs decode straight from flops; nothing on the input side reaches them.
  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_EMIT);
  assign busy      = (state_q != ST_LOAD);
  assign out_word  = out_valid ? win_q[0] : '0;
  assign out_idx   = out_valid ? cnt_q : 6'd0;
  assign out_last  = out_valid & last_cnt;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: reset, "abc" block, back-pressure,
// input gaps, mid-emit reset and back-to-back blocks against a reference schedule.
module tb_sha256_msg_schedule;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [5:0]  out_idx;
  logic        out_last;
  logic        busy;

  int errors = 0;
  int checks = 0;

  sha256_msg_schedule #(.WORD_W(32), .ROUNDS(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word (out_word),
    .out_idx  (out_idx),
    .out_last (out_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish (observed running, required done)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference schedule written directly from the SHA-256 recurrence.
  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  task automatic build_ref(input logic [31:0] m [16], output logic [31:0] w [64]);
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++) w[t] = ref_s1(w[t-2]) + w[t-7] + ref_s0(w[t-15]) + w[t-16];
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_word", out_word, 0);
  endtask

  task automatic load_block(input logic [31:0] m [16], input int gap);
    for (int i = 0; i < 16; i++) begin
      int guard = 0;
      while (!in_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      check("load_in_ready", in_ready, 1);
      check("load_out_valid", out_valid, 0);
      in_valid = 1'b1;
      in_word  = m[i];
      @(negedge clk);
      in_valid = 1'b0;
      in_word  = $urandom;
      if (i != 15) repeat (gap) @(negedge clk);
    end
  endtask

  // Consumes words until stop_at handshakes are done; every sampled cycle the
  // presented word must be the one for the current index, which also proves
  // stability while out_ready is low.
  task automatic emit_block(input logic [31:0] exp [64], input bit rand_ready,
                            input bit poke_in, input int stop_at);
    int idx = 0;
    int guard = 0;
    while (idx < stop_at && guard < 1000) begin
      guard++;
      check("emit_out_valid", out_valid, 1);
      check("emit_busy", busy, 1);
      check("emit_in_ready", in_ready, 0);
      check($sformatf("emit_word[%0d]", idx), out_word, exp[idx]);
      check("emit_out_idx", out_idx, idx);
      check("emit_out_last", out_last, (idx == 63) ? 1 : 0);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke_in) begin
        in_valid = 1'b1;
        in_word  = $urandom;
      end
      @(negedge clk);
      if (out_ready) idx++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("emit_within_budget", (guard < 1000) ? 1 : 0, 1);
    if (!rand_ready) check("emit_cycles", guard, stop_at);
    if (stop_at == 64) begin
      check("post_in_ready", in_ready, 1);
      check("post_busy", busy, 0);
      check("post_out_valid", out_valid, 0);
    end
  endtask

  initial begin
    logic [31:0] m [16];
    logic [31:0] abc_exp [64];
    logic [31:0] exp [64];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b0;

    // 1. Reset held two cycles.
    do_reset(2);

    // 2. "abc" block with sustained out_ready.
    for (int i = 0; i < 16; i++) m[i] = '0;
    m[0]  = 32'h61626380;
    m[15] = 32'h00000018;
    build_ref(m, abc_exp);
    abc_exp[16] = 32'h61626380;
    abc_exp[17] = 32'h000F0000;
    load_block(m, 0);
    emit_block(abc_exp, 1'b0, 1'b0, 64);

    // 3. Same block under random back-pressure.
    load_block(m, 0);
    emit_block(abc_exp, 1'b1, 1'b0, 64);

    // 4. Input gaps of 3 cycles; in_valid asserted with junk during EMIT.
    load_block(m, 3);
    emit_block(abc_exp, 1'b0, 1'b1, 64);

    // 5. Reset mid-EMIT at index 30, then an all-ones block.
    for (int i = 0; i < 16; i++) m[i] = $urandom;
    build_ref(m, exp);
    load_block(m, 0);
    emit_block(exp, 1'b0, 1'b0, 30);
    check("mid_out_idx", out_idx, 30);
    check("mid_out_word", out_word, exp[30]);
    do_reset(1);
    for (int i = 0; i < 16; i++) m[i] = 32'hFFFFFFFF;
    build_ref(m, exp);
    load_block(m, 0);
    emit_block(exp, 1'b0, 1'b0, 64);

    // 6. Back-to-back blocks with no idle cycle between them.
    for (int i = 0; i < 16; i++) m[i] = $urandom;
    build_ref(m, exp);
    load_block(m, 0);
    emit_block(exp, 1'b1, 1'b0, 64);
    for (int i = 0; i < 16; i++) m[i] = 32'h01010101 * (i + 1);
    build_ref(m, exp);
    load_block(m, 0);
    emit_block(exp, 1'b0, 1'b0, 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
